// File: rtl/count_sched.sv
// count_sched: two-requester round-robin burst scheduler for a counter datapath.
// Each accepted burst runs CLEAR -> LEN counts (pausable by hold) -> FINISH; val shadows the count modulo MOD.
module count_sched #(
  parameter int MOD = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [2:0] req0_len,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_len,
  output logic       req1_ready,
  input  logic       hold,
  output logic       cnt,
  output logic       clr,
  output logic [2:0] val,
  output logic       gnt,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;
  localparam logic [2:0] VAL_MAX   = 3'(MOD - 1);

  logic [1:0] state_r;
  logic [2:0] rem_r;
  logic [2:0] val_r;
  logic       gnt_r;
  logic       any_s;
  logic       win_s;
  logic [2:0] win_len_s;

  // Round-robin pick: on contention the requester opposite the last owner wins.
  always_comb begin
    any_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      win_s = ~gnt_r;
    end else begin
      win_s = req1_valid;
    end
    if (win_s) begin
      win_len_s = req1_len;
    end else begin
      win_len_s = req0_len;
    end
  end

  // Handshake and datapath strobes are pure state decodes; ready is masked while reset is asserted.
  always_comb begin
    req0_ready = rst_n & (state_r == ST_IDLE) & any_s & ~win_s;
    req1_ready = rst_n & (state_r == ST_IDLE) & any_s & win_s;
    clr        = (state_r == ST_CLEAR);
    cnt        = (state_r == ST_COUNT) & ~hold;
    done       = (state_r == ST_FINISH);
    busy       = (state_r != ST_IDLE);
    val        = val_r;
    gnt        = gnt_r;
  end

  // Burst sequencer: state, remaining length, shadow value and owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      rem_r   <= 3'd0;
      val_r   <= 3'd0;
      gnt_r   <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            rem_r   <= win_len_s;
            gnt_r   <= win_s;
            state_r <= ST_CLEAR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          val_r <= 3'd0;
          if (rem_r != 3'd0) begin
            state_r <= ST_COUNT;
          end else begin
            state_r <= ST_FINISH;
          end
        end
        ST_COUNT: begin
          if (!hold) begin
            val_r <= (val_r == VAL_MAX) ? 3'd0 : val_r + 3'd1;
            rem_r <= rem_r - 3'd1;
            // rem_r == 0 cannot occur here, but treating it as last keeps the FSM from running away
            if (rem_r <= 3'd1) begin
              state_r <= ST_FINISH;
            end else begin
              state_r <= ST_COUNT;
            end
          end else begin
            state_r <= ST_COUNT;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter MOD, default 7: modulus of the shadow counter, legal range 2..8, so VAL counts 0..MOD-1.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset; asserting it forces reset state immediately, deassertion is sampled on CLK.
REQ-004 REQ0_VALID  input  1  requester 0 has a count burst pending.
REQ-005 REQ0_LEN  input  3  requester 0 burst length, 0..7 counts.
REQ-006 REQ0_READY  output  1  requester 0 burst accepted this cycle.
REQ-007 REQ1_VALID  input  1  requester 1 has a count burst pending.
REQ-008 REQ1_LEN  input  3  requester 1 burst length, 0..7 counts.
REQ-009 REQ1_READY  output  1  requester 1 burst accepted this cycle.
REQ-010 HOLD  input  1  pause counting while in COUNT.
REQ-011 CNT  output  1  count enable to the counter datapath.
REQ-012 CLR  output  1  one-cycle synchronous clear to the counter datapath.
REQ-013 VAL  output  3  shadow count value.
REQ-014 GNT  output  1  owner of the current or last burst: 0 = requester 0, 1 = requester 1.
REQ-015 BUSY  output  1  high in every state except IDLE.
REQ-016 DONE  output  1  one-cycle burst-complete pulse.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, CLEAR, COUNT, FINISH.
REQ-018 IDLE SHALL accept a burst when any VALID is high: both high -> the requester opposite to GNT wins (round-robin); only one high -> that one wins.
REQ-019 READYx SHALL be combinational, high only in IDLE for the winning requester, and never high for both at once.
REQ-020 On acceptance (VALID & READY), LEN SHALL be captured into a 3-bit remaining counter, GNT SHALL be set to the winner, and the FSM SHALL go to CLEAR.
REQ-021 VALID with no READY SHALL be held by the requester; LEN may change while not accepted.
REQ-022 CLEAR SHALL last exactly one cycle with CLR=1 and VAL<=0, then go to COUNT if remaining != 0, else to FINISH.
REQ-023 COUNT with HOLD=0 SHALL drive CNT=1, advance VAL by 1 modulo MOD (MOD-1 -> 0), and decrement remaining; when remaining==1 the next state is FINISH.
REQ-024 COUNT with HOLD=1 SHALL drive CNT=0 and freeze VAL and remaining; HOLD is ignored in every other state.
REQ-025 FINISH SHALL last one cycle with DONE=1, then return to IDLE; VAL holds its final value until the next CLEAR.
REQ-026 Latency: acceptance at cycle t, no HOLD -> CLR at t+1, CNT at t+2..t+1+LEN, DONE at t+2+LEN.
REQ-027 LEN=0 SHALL produce CLEAR then FINISH with no CNT pulse, so DONE is at t+2.
REQ-028 Changes on VALID/LEN during CLEAR/COUNT/FINISH SHALL be ignored; a new burst is accepted no earlier than the cycle after FINISH.
REQ-029 CNT, CLR and DONE SHALL be mutually exclusive in every cycle.

Reset
REQ-030 RST_N low SHALL asynchronously force state=IDLE, VAL=0, remaining=0, GNT=1 (so requester 0 wins first contention), and CNT=CLR=DONE=BUSY=0.
REQ-031 RST_N low SHALL force READY0 and READY1 to 0.
REQ-032 Reset during any state, including mid-COUNT, SHALL abort the burst with no DONE pulse.

Verification
REQ-033 Reset, then REQ0_VALID=1 LEN=3 -> READY0 at t, CLR at t+1, CNT t+2..t+4 with VAL 1,2,3, DONE at t+5, GNT=0.
REQ-034 Both VALID from reset, LEN0=2 LEN1=1 -> requester 0 served first (DONE after 2 counts), then requester 1 (GNT=1, 1 count); alternation continues while both stay high.
REQ-035 MOD=7, LEN=7 -> VAL sequence 1,2,3,4,5,6,0; seven CNT pulses; DONE follows.
REQ-036 LEN=4, HOLD high for 3 cycles after the second CNT -> CNT low and VAL frozen at 2 for 3 cycles, then VAL 3,4; DONE delayed by 3 cycles.
REQ-037 LEN=0 -> CLR then DONE next cycle, no CNT, VAL=0.
REQ-038 RST_N pulsed low mid-COUNT of LEN=5 -> outputs immediately return to reset values, no DONE; the next request is served from IDLE normally.
